uctl_sys_controller_tx: RTL

- System-side write controller for the USB core: moves 1..16 packets from system memory into one endpoint buffer, sequenced per packet.
- Sits between the register block and the system endpoint write controller (sepw). It is the transmit-direction counterpart of the system read controller.
- Per packet sequence: get write pointers → check full → stream data → write header → update buffer, repeated until the requested count is reached.

---
 rtl/uctl_sys_controller_tx.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/uctl_sys_controller_tx.sv
// System-side transmit controller: moves 1..16 packets from system memory into one endpoint buffer via sepw.
// Optional full-retry backoff (WAIT state) enabled by defining UCTL_SCTRLTX_FULL_RETRY_EN.
module uctl_sys_controller_tx #(
  parameter int unsigned PKTCNTWD     = 9,
  parameter int unsigned RETRY_CYCLES = 16,
  parameter int unsigned RETRY_LIMIT  = 4
) (
  input  logic                coreClk,
  input  logic                uctl_rst_n,
  input  logic                sw_rst,
  input  logic                reg2sctrlTx_wr,
  input  logic [3:0]          reg2sctrlTx_epNum,
  input  logic [3:0]          reg2sctrlTx_wrCount,
  input  logic                reg2sctrlTx_listMode,
  output logic                sctrlTx2reg_updtWrBuf,
  output logic [3:0]          sctrlTx2reg_wrCnt,
  output logic [1:0]          sctrlTx2reg_status,
  output logic                sctrlTx2reg_full,
  output logic [4:0]          sctrlTx2reg_freePktCnt,
  input  logic                sepw2sctrlTx_bufFull,
  input  logic                sepw2sctrlTx_wrPtrsRcvd,
  input  logic                sepw2sctrlTx_transferDn,
  input  logic                sepw2sctrlTx_hdrWrDn,
  input  logic                sepw2sctrlTx_bufUpdtDn,
  input  logic [PKTCNTWD-1:0] sepw2sctrlTx_freePktCnt,
  output logic                sctrlTx2sepw_inIdle,
  output logic [3:0]          sctrlTx2sepw_epNum,
  output logic                sctrlTx2sepw_getWrPtrs,
  output logic                sctrlTx2sepw_wr,
  output logic                sctrlTx2sepw_hdrWr,
  output logic                sctrlTx2sepw_updtWrBuf,
  output logic                sctrlTx2sepw_rdAddrEn
);

  if (PKTCNTWD < 5 || RETRY_CYCLES < 1 || RETRY_LIMIT < 1) begin : g_bad_cfg
    $error("uctl_sys_controller_tx: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRPTR  = 3'd1,
    S_WRDATA = 3'd2,
    S_WRHDR  = 3'd3,
    S_UPDT   = 3'd4
`ifdef UCTL_SCTRLTX_FULL_RETRY_EN
    , S_WAIT = 3'd5
`endif
  } state_e;

  localparam logic [1:0] ST_DONE  = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b10;
  localparam logic [1:0] ST_ABORT = 2'b01;

  state_e     state_q, state_d;
  logic [3:0] pkt_done_q, pkt_done_d;
  logic       hold;
  logic       give_up;

`ifdef UCTL_SCTRLTX_FULL_RETRY_EN
  localparam int unsigned WCW = (RETRY_CYCLES > 1) ? $clog2(RETRY_CYCLES) : 1;
  localparam int unsigned RCW = $clog2(RETRY_LIMIT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(RETRY_CYCLES - 1);
  localparam logic [RCW-1:0] RETRY_MAX = RCW'(RETRY_LIMIT);

  logic [WCW-1:0] wait_q, wait_d;
  logic [RCW-1:0] retry_q, retry_d;

  always_comb give_up = (retry_q == RETRY_MAX);
`else
  always_comb give_up = 1'b1;
`endif

  // Reset (async or software) forces the idle decode so no strobe leaks out while it is held.
  always_comb hold = sw_rst | ~uctl_rst_n;

  always_comb begin
    state_d                = state_q;
    pkt_done_d             = pkt_done_q;
`ifdef UCTL_SCTRLTX_FULL_RETRY_EN
    wait_d                 = wait_q;
    retry_d                = retry_q;
`endif
    sctrlTx2sepw_inIdle    = 1'b0;
    sctrlTx2sepw_getWrPtrs = 1'b0;
    sctrlTx2sepw_wr        = 1'b0;
    sctrlTx2sepw_hdrWr     = 1'b0;
    sctrlTx2sepw_updtWrBuf = 1'b0;
    sctrlTx2sepw_rdAddrEn  = 1'b0;
    sctrlTx2reg_updtWrBuf  = 1'b0;
    sctrlTx2reg_full       = 1'b0;
    sctrlTx2reg_status     = ST_DONE;

    if (hold) begin
      state_d             = S_IDLE;
      pkt_done_d          = '0;
      sctrlTx2sepw_inIdle = 1'b1;
`ifdef UCTL_SCTRLTX_FULL_RETRY_EN
      wait_d              = '0;
      retry_d             = '0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          sctrlTx2sepw_inIdle = 1'b1;
          pkt_done_d          = '0;
`ifdef UCTL_SCTRLTX_FULL_RETRY_EN
          retry_d             = '0;
          wait_d              = '0;
`endif
          if (reg2sctrlTx_wr) begin
            sctrlTx2sepw_rdAddrEn  = 1'b1;
            sctrlTx2sepw_getWrPtrs = 1'b1;
            sctrlTx2reg_updtWrBuf  = 1'b1;
            sctrlTx2reg_status     = ST_BUSY;
            state_d                = S_WRPTR;
          end
        end

        S_WRPTR: begin
          sctrlTx2sepw_getWrPtrs = 1'b1;
          sctrlTx2reg_status     = ST_BUSY;
          if (sepw2sctrlTx_wrPtrsRcvd) begin
            if (reg2sctrlTx_listMode) begin
              state_d = S_UPDT;
            end else if (sepw2sctrlTx_bufFull) begin
              if (give_up) begin
                sctrlTx2reg_updtWrBuf = 1'b1;
                sctrlTx2reg_full      = 1'b1;
                sctrlTx2reg_status    = ST_ABORT;
                state_d               = S_IDLE;
              end else begin
`ifdef UCTL_SCTRLTX_FULL_RETRY_EN
                retry_d = retry_q + 1'b1;
                wait_d  = '0;
                state_d = S_WAIT;
`endif
              end
            end else begin
`ifdef UCTL_SCTRLTX_FULL_RETRY_EN
              retry_d = '0;
`endif
              state_d = S_WRDATA;
            end
          end
        end

        S_WRDATA: begin
          sctrlTx2sepw_wr    = 1'b1;
          sctrlTx2reg_status = ST_BUSY;
          if (sepw2sctrlTx_transferDn) state_d = S_WRHDR;
        end

        // Header goes after data since it carries the byte count of the packet just streamed.
        S_WRHDR: begin
          sctrlTx2sepw_hdrWr = 1'b1;
          sctrlTx2reg_status = ST_BUSY;
          if (sepw2sctrlTx_hdrWrDn) state_d = S_UPDT;
        end

        S_UPDT: begin
          if (reg2sctrlTx_listMode) begin
            sctrlTx2reg_updtWrBuf = 1'b1;
            sctrlTx2reg_status    = ST_DONE;
            state_d               = S_IDLE;
          end else begin
            sctrlTx2sepw_updtWrBuf = 1'b1;
            sctrlTx2reg_status     = ST_BUSY;
            if (sepw2sctrlTx_bufUpdtDn) begin
              if (pkt_done_q == reg2sctrlTx_wrCount) begin
                sctrlTx2reg_updtWrBuf = 1'b1;
                sctrlTx2reg_status    = ST_DONE;
                state_d               = S_IDLE;
              end else begin
                pkt_done_d = pkt_done_q + 4'd1;
                state_d    = S_WRPTR;
              end
            end
          end
        end

`ifdef UCTL_SCTRLTX_FULL_RETRY_EN
        S_WAIT: begin
          sctrlTx2reg_status = ST_BUSY;
          if (wait_q == WAIT_LAST) begin
            wait_d  = '0;
            state_d = S_WRPTR;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
`endif

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge coreClk or negedge uctl_rst_n) begin
    if (!uctl_rst_n) begin
      state_q    <= S_IDLE;
      pkt_done_q <= '0;
`ifdef UCTL_SCTRLTX_FULL_RETRY_EN
      wait_q     <= '0;
      retry_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pkt_done_q <= pkt_done_d;
`ifdef UCTL_SCTRLTX_FULL_RETRY_EN
      wait_q     <= wait_d;
      retry_q    <= retry_d;
`endif
    end
  end

  always_comb begin
    sctrlTx2reg_wrCnt  = reg2sctrlTx_wrCount - pkt_done_q;
    sctrlTx2sepw_epNum = reg2sctrlTx_epNum;
    if (sepw2sctrlTx_freePktCnt > PKTCNTWD'(30)) sctrlTx2reg_freePktCnt = 5'd31;
    else                                         sctrlTx2reg_freePktCnt = sepw2sctrlTx_freePktCnt[4:0];
  end

endmodule
